// File: rtl/loop_buffer_sync_if.sv
// Loop buffer port bundle: block write side, head-block read side and status flags.
interface loop_buffer_sync_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int BLK_WIDTH  = 2,
  parameter int INFO_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_wen;
  logic                  wr_wlast;
  logic                  wr_abort;
  logic [INFO_WIDTH-1:0] wr_info;
  logic                  wr_full;
  logic [BLK_WIDTH:0]    free_size;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_dvld;
  logic                  rd_vld;
  logic [INFO_WIDTH-1:0] rd_info;
  logic                  rd_rdy;
  logic [15:0]           drop_cnt;

  modport master (
    output wr_addr, wr_data, wr_wen, wr_wlast, wr_abort, wr_info, rd_en, rd_addr, rd_rdy,
    input  wr_full, free_size, rd_data, rd_dvld, rd_vld, rd_info, drop_cnt
  );

  modport slave (
    input  wr_addr, wr_data, wr_wen, wr_wlast, wr_abort, wr_info, rd_en, rd_addr, rd_rdy,
    output wr_full, free_size, rd_data, rd_dvld, rd_vld, rd_info, drop_cnt
  );
endinterface

// File: rtl/loop_buffer_sync.sv
// Block-granular loop buffer: NBLK blocks committed in order, read from the head with READ_LATENCY cycles.
// Define LOOP_BUFFER_DROP_CNT_EN to count commits rejected while full; otherwise drop_cnt is tied to zero.
module loop_buffer_sync #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int BLK_WIDTH    = 2,
  parameter int INFO_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  loop_buffer_sync_if.slave bus
);
  localparam int NBLK  = 2 ** BLK_WIDTH;
  localparam int DEPTH = NBLK * (2 ** ADDR_WIDTH);
  localparam int CW    = BLK_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem      [0:DEPTH-1];
  logic [INFO_WIDTH-1:0] info_mem [0:NBLK-1];

  logic [BLK_WIDTH-1:0]  wbadr, rbadr, wbadr_nxt, rbadr_nxt;
  logic [CW-1:0]         used, used_nxt, free_q;
  logic                  full_q, vld_q;
  logic [INFO_WIDTH-1:0] info_q, info_nxt;
  logic                  wr_ok, commit, release_blk, rd_ok;

  logic [DATA_WIDTH-1:0]   dpipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] vpipe;

  always_comb begin
    wr_ok       = bus.wr_wen && !full_q;
    commit      = bus.wr_wlast && !bus.wr_abort && !full_q;
    release_blk = bus.rd_rdy && vld_q;
    rd_ok       = bus.rd_en && vld_q;
    wbadr_nxt   = commit ? wbadr + 1'b1 : wbadr;
    rbadr_nxt   = release_blk ? rbadr + 1'b1 : rbadr;
    used_nxt    = used;
    if (commit && !release_blk)
      used_nxt = used + 1'b1;
    else if (!commit && release_blk)
      used_nxt = used - 1'b1;
    // The block being committed this cycle may become the new head; its info is not in info_mem yet.
    info_nxt = (commit && (wbadr == rbadr_nxt)) ? bus.wr_info : info_mem[rbadr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{wbadr, bus.wr_addr}] <= bus.wr_data;
    if (commit)
      info_mem[wbadr] <= bus.wr_info;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbadr  <= '0;
      rbadr  <= '0;
      used   <= '0;
      full_q <= 1'b0;
      vld_q  <= 1'b0;
      free_q <= CW'(NBLK);
      info_q <= '0;
    end else begin
      wbadr  <= wbadr_nxt;
      rbadr  <= rbadr_nxt;
      used   <= used_nxt;
      full_q <= (used_nxt == CW'(NBLK));
      vld_q  <= (used_nxt != '0);
      free_q <= CW'(NBLK) - used_nxt;
      info_q <= info_nxt;
    end
  end

  // Head block index is captured at issue, so a release in flight cannot redirect the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        dpipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_ok;
      if (rd_ok)
        dpipe[0] <= mem[{rbadr, bus.rd_addr}];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

`ifdef LOOP_BUFFER_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst)
      drop_q <= '0;
    else if (bus.wr_wlast && !bus.wr_abort && full_q && (drop_q != 16'hFFFF))
      drop_q <= drop_q + 16'd1;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 16'd0;
`endif

  assign bus.wr_full   = full_q;
  assign bus.free_size = free_q;
  assign bus.rd_vld    = vld_q;
  assign bus.rd_info   = info_q;
  assign bus.rd_data   = dpipe[READ_LATENCY-1];
  assign bus.rd_dvld   = vpipe[READ_LATENCY-1];
endmodule

// File: tb/tb_loop_buffer_sync.sv
// Randomised and directed bench for loop_buffer_sync; block-queue reference model with a read scoreboard.
module tb_loop_buffer_sync;
  localparam int DW   = 64;
  localparam int AW   = 8;
  localparam int BW   = 2;
  localparam int IW   = 32;
  localparam int RL   = 2;
  localparam int NBLK = 1 << BW;
  localparam int WPB  = 1 << AW;

  typedef struct packed {
    bit          rst;
    bit          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    bit          wlast;
    bit          abort;
    logic [IW-1:0] info;
    bit          ren;
    logic [AW-1:0] raddr;
    bit          rrdy;
  } stim_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            known;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loop_buffer_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_WIDTH(BW), .INFO_WIDTH(IW)) bus ();

  loop_buffer_sync #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_WIDTH(BW), .INFO_WIDTH(IW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: committed blocks as a FIFO of infos, storage as [block][word].
  logic [DW-1:0] mm [NBLK][WPB];
  bit            mk [NBLK][WPB];
  logic [IW-1:0] infq [$];
  exp_t          expq [$];
  int wb = 0, rb = 0, drops = 0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    int sz;
    rst          = s.rst;
    bus.wr_wen   = s.wen;
    bus.wr_addr  = s.waddr;
    bus.wr_data  = s.wdata;
    bus.wr_wlast = s.wlast;
    bus.wr_abort = s.abort;
    bus.wr_info  = s.info;
    bus.rd_en    = s.ren;
    bus.rd_addr  = s.raddr;
    bus.rd_rdy   = s.rrdy;
    sz = infq.size();
    if (s.rst) begin
      infq.delete();
      expq.delete();
      wb = 0;
      rb = 0;
      drops = 0;
      foreach (mk[i, j]) mk[i][j] = 1'b0;
    end else begin
      if (s.ren && sz != 0)
        expq.push_back('{data: mm[rb][s.raddr], known: mk[rb][s.raddr], due: cyc + RL});
      if (s.wen && sz != NBLK) begin
        mm[wb][s.waddr] = s.wdata;
        mk[wb][s.waddr] = 1'b1;
      end
      if (s.wlast && !s.abort) begin
        if (sz != NBLK) begin
          infq.push_back(s.info);
          wb = (wb + 1) % NBLK;
        end else if (drops < 16'hFFFF) begin
          drops++;
        end
      end
      if (s.rrdy && sz != 0) begin
        void'(infq.pop_front());
        rb = (rb + 1) % NBLK;
      end
    end
    @(negedge clk);
    chk("free_size", bus.free_size, NBLK - infq.size());
    chk("wr_full", bus.wr_full, infq.size() == NBLK);
    chk("rd_vld", bus.rd_vld, infq.size() != 0);
    if (infq.size() != 0)
      chk("rd_info", bus.rd_info, infq[0]);
`ifdef LOOP_BUFFER_DROP_CNT_EN
    chk("drop_cnt", bus.drop_cnt, drops);
`else
    chk("drop_cnt", bus.drop_cnt, 0);
`endif
    #1;
  endtask

  // Scoreboard monitor: every rd_dvld must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (bus.rd_dvld) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_dvld_unexpected: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("rd_dvld_cycle", cyc, e.due);
          if (e.known)
            chk("rd_data", bus.rd_data, e.data);
        end
      end else if (expq.size() != 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL rd_dvld_missing: got 0, expected 1 (cycle %0d)", cyc);
      end
    end
  end

  task automatic write_block(input logic [DW-1:0] base, input logic [IW-1:0] info,
                             input bit commit, input int nwords);
    stim_t s;
    for (int a = 0; a < nwords; a++) begin
      s = idle();
      s.wen   = 1'b1;
      s.waddr = AW'(a);
      s.wdata = base + DW'(a);
      s.wlast = commit && (a == nwords - 1);
      s.info  = info;
      step(s);
    end
  endtask

  task automatic read_words(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = idle();
      s.ren   = 1'b1;
      s.raddr = AW'($urandom);
      step(s);
    end
  endtask

  task automatic release_n(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = idle();
      s.rrdy = 1'b1;
      step(s);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  initial begin
    stim_t s;
    bus.wr_wen = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_wlast = 0; bus.wr_abort = 0;
    bus.wr_info = '0; bus.rd_en = 0; bus.rd_addr = '0; bus.rd_rdy = 0;
    @(negedge clk);
    #1;

    // Reset state
    s = idle();
    s.rst = 1'b1;
    step(s);
    started = 1'b1;
    step(s);
    chk("reset_rd_info", bus.rd_info, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    chk("reset_rd_dvld", bus.rd_dvld, 0);

    // Single block commit and one read
    write_block(0, 32'hA5, 1, WPB);
    chk("first_commit_free", bus.free_size, 3);
    chk("first_commit_info", bus.rd_info, 32'hA5);
    s = idle();
    s.ren = 1'b1;
    s.raddr = 8'd7;
    step(s);
    idle_n(1);
    chk("first_read_dvld", bus.rd_dvld, 1);
    chk("first_read_data", bus.rd_data, 7);
    idle_n(2);

    // Commit and release in the same cycle with two blocks held
    write_block(64'h1000, 32'hB6, 1, WPB);
    write_block(64'h2000, 32'hC7, 0, WPB - 1);
    s = idle();
    s.wen = 1'b1; s.waddr = AW'(WPB - 1); s.wdata = 64'h2000 + DW'(WPB - 1);
    s.wlast = 1'b1; s.info = 32'hC7; s.rrdy = 1'b1;
    step(s);
    chk("swap_free", bus.free_size, 2);
    chk("swap_info", bus.rd_info, 32'hB6);
    read_words(8);
    release_n(3);

    // Fill to full, write and commit while full
    for (int k = 0; k < NBLK; k++)
      write_block(64'h3000 + DW'(k * WPB), IW'(32'h10 + k), 1, WPB);
    chk("full_flag", bus.wr_full, 1);
    chk("full_free", bus.free_size, 0);
    s = idle();
    s.wen = 1'b1; s.waddr = '0; s.wdata = 64'hDEAD_BEEF;
    step(s);
    s = idle();
    s.wlast = 1'b1; s.info = 32'h99;
    step(s);
`ifdef LOOP_BUFFER_DROP_CNT_EN
    chk("drop_one", bus.drop_cnt, 1);
`else
    chk("drop_off", bus.drop_cnt, 0);
`endif
    chk("drop_info_kept", bus.rd_info, 32'h10);
    s = idle();
    s.ren = 1'b1; s.raddr = '0;
    step(s);
    read_words(6);
    release_n(NBLK);

    // Abort a half block, then rewrite and commit
    write_block(64'h5000, 32'hD1, 0, WPB / 2);
    s = idle();
    s.abort = 1'b1; s.wlast = 1'b1; s.info = 32'hD1;
    step(s);
    chk("abort_free", bus.free_size, NBLK);
    write_block(64'h6000, 32'hD2, 1, WPB);
    chk("rewrite_free", bus.free_size, NBLK - 1);
    chk("rewrite_info", bus.rd_info, 32'hD2);
    read_words(16);
    release_n(1);

    // Nine blocks through the ring, then release while empty
    for (int k = 0; k < 9; k++) begin
      write_block(64'h7000 + DW'(k * 300), IW'(32'hE0 + k), 1, WPB);
      read_words(4);
      release_n(1);
    end
    release_n(1);
    chk("empty_release_free", bus.free_size, NBLK);
    chk("empty_release_vld", bus.rd_vld, 0);

    // Reset with blocks held and reads in flight
    write_block(64'h9000, 32'hF1, 1, WPB);
    write_block(64'hA000, 32'hF2, 1, WPB);
    read_words(3);
    s = idle();
    s.rst = 1'b1; s.ren = 1'b1;
    step(s);
    chk("rst_mid_free", bus.free_size, NBLK);
    chk("rst_mid_vld", bus.rd_vld, 0);
    chk("rst_mid_dvld", bus.rd_dvld, 0);
    idle_n(RL + 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 999) == 0);
      s.wen   = ($urandom_range(0, 9) < 6);
      s.waddr = AW'($urandom);
      s.wdata = {$urandom, $urandom};
      s.wlast = ($urandom_range(0, 19) == 0);
      s.abort = ($urandom_range(0, 59) == 0);
      s.info  = $urandom;
      s.ren   = ($urandom_range(0, 1) == 1);
      s.raddr = AW'($urandom);
      s.rrdy  = ($urandom_range(0, 14) == 0);
      step(s);
    end

    idle_n(RL + 3);
    chk("reads_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/loop_buffer_sync.md
LOOP_BUFFER_SYNC -- requirements
Module: loop_buffer_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of every data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: word address inside one block; block holds 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BLK_WIDTH, default 2: block index width; buffer holds NBLK = 2**BLK_WIDTH blocks (BLK_WIDTH >= 1).
REQ-004 SHALL have parameter INFO_WIDTH, default 32: per-block side-info width.
REQ-005 SHALL have parameter READ_LATENCY, default 2, legal 1..3: rd_en to rd_data cycles.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_addr  in  ADDR_WIDTH  word address inside current write block.
REQ-009 wr_data  in  DATA_WIDTH  write data.
REQ-010 wr_wen  in  1  write strobe.
REQ-011 wr_wlast  in  1  commit current write block (1-cycle pulse).
REQ-012 wr_abort  in  1  discard current partially written block.
REQ-013 wr_info  in  INFO_WIDTH  side-info captured at commit.
REQ-014 wr_full  out  1  all NBLK blocks committed and unreleased.
REQ-015 free_size  out  BLK_WIDTH+1  number of free blocks, 0..NBLK.
REQ-016 rd_en  in  1  read request at {head block, rd_addr}.
REQ-017 rd_addr  in  ADDR_WIDTH  word address inside head block.
REQ-018 rd_data  out  DATA_WIDTH  read data.
REQ-019 rd_dvld  out  1  rd_data valid strobe.
REQ-020 rd_vld  out  1  at least one committed block available.
REQ-021 rd_info  out  INFO_WIDTH  side-info of head block.
REQ-022 rd_rdy  in  1  release head block (1-cycle pulse).
REQ-023 drop_cnt  out  16  count of commits rejected while full.

Function
REQ-024 Write word SHALL be stored at {wbadr, wr_addr} when wr_wen=1 and wr_full=0; ignored when wr_full=1.
REQ-025 wr_wlast=1, wr_abort=0, wr_full=0 SHALL store wr_info for block wbadr, increment wbadr modulo NBLK, increment used count.
REQ-026 wr_wlast with wr_full=1 SHALL be dropped: no pointer/count change; counts as one drop event.
REQ-027 wr_abort=1 SHALL leave wbadr and used count unchanged; same-cycle wr_wlast SHALL be ignored (abort wins), not a drop event.
REQ-028 rd_rdy=1 with rd_vld=1 SHALL increment rbadr modulo NBLK and decrement used count; rd_rdy with rd_vld=0 SHALL be ignored.
REQ-029 Simultaneous accepted commit and release SHALL leave used count unchanged and move both pointers.
REQ-030 free_size SHALL equal NBLK - used; wr_full = (used == NBLK); rd_vld = (used != 0); all registered, updated the cycle after the event.
REQ-031 rd_info SHALL show info of block rbadr whenever rd_vld=1; value undefined-but-stable when rd_vld=0.
REQ-032 rd_en=1 with rd_vld=1 SHALL return word {rbadr, rd_addr} on rd_data with rd_dvld=1 exactly READ_LATENCY cycles later; block index sampled at issue, so a release in flight does not alter the returned word.
REQ-033 rd_en with rd_vld=0 SHALL produce no rd_dvld.
REQ-034 Back-to-back rd_en SHALL sustain one word per cycle.
REQ-035 Same-cycle write and read to one address cannot occur (head block is never the write block while used<NBLK); no bypass required.

Reset
REQ-036 rst=1 SHALL clear wbadr, rbadr, used count, read pipeline, drop_cnt; free_size=NBLK, wr_full=0, rd_vld=0, rd_dvld=0, rd_info=0, rd_data=0.
REQ-037 rst mid-operation SHALL discard all blocks and in-flight reads; memory contents need not be cleared.

Configuration
REQ-038 Macro LOOP_BUFFER_DROP_CNT_EN defined: drop_cnt increments by 1 per drop event (REQ-026), saturates at 16'hFFFF.
REQ-039 Macro absent: drop_cnt SHALL be constant 0 and no counter logic instantiated.

Verification
REQ-040 Defaults: write block 0 words 0..255 = index, wlast with info=0xA5 -> free_size 4->3, rd_vld=1, rd_info=0xA5; rd_en addr 7 -> rd_data=7, rd_dvld 2 cycles later.
REQ-041 Commit 4 blocks -> wr_full=1, free_size=0; 5th wlast -> drop_cnt=1 (macro on), 0 (macro off), rbadr/wbadr unchanged.
REQ-042 Write half block, wr_abort, rewrite full block with wlast -> only one block committed, rewritten data read back.
REQ-043 used=2, same-cycle wlast and rd_rdy -> free_size stays 2, rd_info advances to next block's info.
REQ-044 Commit/release 9 blocks sequentially -> pointer wraps, each block's data/info intact; rd_rdy when empty -> no change.
REQ-045 rst asserted with 2 blocks and reads in flight -> next cycle free_size=4, rd_vld=0, no rd_dvld.
